// File: rtl/response_transmitter_if.sv
// Response handshake between the command engines and the UART return path.
// The engine side drives a response and its valid; the transmitter answers with ready.
interface response_transmitter_if;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_op;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_key;
  logic [31:0] rsp_value;

  modport master (
    output rsp_valid, rsp_op, rsp_status, rsp_key, rsp_value,
    input  rsp_ready
  );

  modport slave (
    input  rsp_valid, rsp_op, rsp_status, rsp_key, rsp_value,
    output rsp_ready
  );
endinterface

// File: rtl/response_transmitter.sv
// UART return path: frames one key-value response as 10 bytes (header, key, value,
// XOR checksum) and serializes them 8N1 on dcom_tx, paced by the shared baud tick.
module response_transmitter #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_in,
  response_transmitter_if.slave        rsp,
  output logic                         dcom_tx,
  output logic                         busy,
  output logic                         frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BYTE = 4'd9;

  function automatic logic [79:0] build_frame(
    input logic [1:0]  op,
    input logic [1:0]  status,
    input logic [31:0] key,
    input logic [31:0] value
  );
    logic [71:0] body;
    logic [7:0]  sum;
    body = {4'hA, status, op, key, value};
    sum  = '0;
    for (int i = 0; i < 9; i++) sum ^= body[8*i +: 8];
    return {body, sum};
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  tick_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [3:0]  byte_idx_q;
  logic [79:0] frame_q;
  logic        tx_d;
  logic        accept;
  logic        bit_end;
  logic        in_bit;
  logic [7:0]  cur_byte;

  assign in_bit   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign bit_end  = in_bit && tick_in && (tick_cnt_q == TICK_LAST);
  // Byte 0 sits in the top octet of the frame register.
  assign cur_byte = frame_q[(7'd72 - {byte_idx_q, 3'b000}) +: 8];

  assign rsp.rsp_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    tx_d    = dcom_tx;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (rsp.rsp_valid) begin
          accept  = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_idx_q == LAST_BYTE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Control state: FSM, line level and bit/byte/tick counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dcom_tx    <= 1'b1;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
    end else begin
      state_q <= state_d;
      dcom_tx <= tx_d;
      if (accept) begin
        tick_cnt_q <= '0;
        bit_idx_q  <= '0;
        byte_idx_q <= '0;
      end else if (in_bit && tick_in) begin
        tick_cnt_q <= bit_end ? 8'd0 : tick_cnt_q + 8'd1;
        if (bit_end && state_q == S_DATA) bit_idx_q <= bit_idx_q + 3'd1;
        if (bit_end && state_q == S_STOP && byte_idx_q != LAST_BYTE)
          byte_idx_q <= byte_idx_q + 4'd1;
      end
    end
  end

  // Response capture: frozen for the whole frame once accepted.
  always_ff @(posedge clk) begin
    if (accept) frame_q <= build_frame(rsp.rsp_op, rsp.rsp_status, rsp.rsp_key, rsp.rsp_value);
  end

endmodule

// File: tb/tb_response_transmitter.sv
// Bench for response_transmitter: tick-count line model checked every cycle, plus
// hand-decoded frames, frame lengths and reset behaviour against literal values.
module tb_response_transmitter;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst;
  logic tick_in;
  logic dcom_tx;
  logic busy;
  logic frame_done;

  response_transmitter_if rif ();

  response_transmitter #(.OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .rsp        (rif.slave),
    .dcom_tx    (dcom_tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for each of the 100 bit slots of a frame.
  function automatic logic [99:0] line_bits(input logic [1:0] op, input logic [1:0] st,
                                            input logic [31:0] key, input logic [31:0] val);
    logic [7:0]  b [10];
    logic [99:0] l;
    b[0] = {4'hA, st, op};
    for (int i = 0; i < 4; i++) begin
      b[1+i] = key[31-8*i -: 8];
      b[5+i] = val[31-8*i -: 8];
    end
    b[9] = 8'h00;
    for (int i = 0; i < 9; i++) b[9] ^= b[i];
    for (int i = 0; i < 10; i++) begin
      l[10*i] = 1'b0;
      for (int j = 0; j < 8; j++) l[10*i+1+j] = b[i][j];
      l[10*i+9] = 1'b1;
    end
    return l;
  endfunction

  // Model: after acceptance the line shows slot (ticks counted / OS) until 100*OS ticks.
  logic        m_active = 1'b0;
  logic        m_done = 1'b0;
  logic        m_seen_rst = 1'b0;
  int          m_cnt = 0;
  logic [99:0] m_line = '1;

  always @(posedge clk) begin
    if (rst) begin
      m_active   = 1'b0;
      m_done     = 1'b0;
      m_seen_rst = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (rif.rsp_valid) begin
        m_active = 1'b1;
        m_cnt    = 0;
        m_line   = line_bits(rif.rsp_op, rif.rsp_status, rif.rsp_key, rif.rsp_value);
      end
    end else if (tick_in) begin
      m_cnt++;
      if (m_cnt == 100*OS) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_seen_rst) begin
      chk("model_tx", 64'(dcom_tx), 64'(m_active ? m_line[m_cnt/OS] : 1'b1));
      chk("model_ready", 64'(rif.rsp_ready), 64'(!m_active && !m_done));
      chk("model_busy", 64'(busy), 64'(m_active || m_done));
      chk("model_frame_done", 64'(frame_done), 64'(m_done));
    end
  end

  // Stimulus: every input change happens on a falling edge.
  int   div = 1;
  int   ph = 0;
  logic stall = 1'b0;
  logic lvl [0:7000];
  logic fd  [0:7000];
  logic rdy [0:7000];
  logic [1:0]  n_op, n_st;
  logic [31:0] n_key, n_val;

  task automatic cyc();
    @(negedge clk);
    tick_in = !stall && (ph == div - 1);
    ph = (ph + 1) % div;
  endtask

  task automatic set_rsp(input logic [1:0] op, input logic [1:0] st,
                         input logic [31:0] key, input logic [31:0] val);
    rif.rsp_op     = op;
    rif.rsp_status = st;
    rif.rsp_key    = key;
    rif.rsp_value  = val;
  endtask

  // Entered on the falling edge just before the accepting edge; records cycles 1..n.
  task automatic run_frame(input int n, input bit keep, input int change_at,
                           input int stall_at, input int stall_len);
    for (int c = 1; c <= n; c++) begin
      stall = (stall_len > 0) && (c >= stall_at) && (c < stall_at + stall_len);
      cyc();
      lvl[c] = dcom_tx;
      fd[c]  = frame_done;
      rdy[c] = rif.rsp_ready;
      if (c == 1 && !keep) rif.rsp_valid = 1'b0;
      if (c == change_at) set_rsp(n_op, n_st, n_key, n_val);
    end
    stall = 1'b0;
  endtask

  task automatic decode(input string tag, input int span, input logic [79:0] exp);
    int         bad_w;
    logic [7:0] got;
    bad_w = 0;
    for (int k = 0; k < 100; k++)
      for (int c = k*span + 1; c <= k*span + span; c++)
        if (lvl[c] !== lvl[k*span + 1]) bad_w++;
    chk({tag, "_bit_width_glitches"}, 64'(bad_w), 64'd0);
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < 8; j++) got[j] = lvl[(10*b + 1 + j)*span + 1];
      chk($sformatf("%s_start%0d", tag, b), 64'(lvl[10*b*span + 1]), 64'd0);
      chk($sformatf("%s_byte%0d", tag, b), 64'(got), 64'(exp[79-8*b -: 8]));
      chk($sformatf("%s_stop%0d", tag, b), 64'(lvl[(10*b + 9)*span + 1]), 64'd1);
    end
  endtask

  initial begin
    int rdy_hi;
    int held;
    rst = 1'b1;
    tick_in = 1'b0;
    rif.rsp_valid = 1'b0;
    set_rsp(2'd0, 2'd0, 32'd0, 32'd0);

    // Reset state after 3 clocks of rst.
    repeat (3) cyc();
    chk("rst_tx", 64'(dcom_tx), 64'd1);
    chk("rst_ready", 64'(rif.rsp_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    rst = 1'b0;
    cyc();

    // Frame at one tick per clock.
    div = 1; ph = 0;
    cyc();
    set_rsp(2'd0, 2'd1, 32'h12345678, 32'h0000ABCD);
    rif.rsp_valid = 1'b1;
    run_frame(1601, 1'b0, 0, 0, 0);
    decode("f1", 16, 80'hA4_12345678_0000ABCD_CA);
    chk("f1_done_1600", 64'(fd[1600]), 64'd0);
    chk("f1_done_1601", 64'(fd[1601]), 64'd1);
    chk("f1_busy_c1", 64'(rdy[1]), 64'd0);

    // One tick every 4 clocks: 64-clock bits, 6400-clock frame.
    div = 4;
    cyc();
    set_rsp(2'd2, 2'd3, 32'hDEADBEEF, 32'h01020304);
    rif.rsp_valid = 1'b1;
    ph = 0;
    run_frame(6401, 1'b0, 0, 0, 0);
    decode("f2", 64, 80'hAE_DEADBEEF_01020304_88);
    chk("f2_done_6400", 64'(fd[6400]), 64'd0);
    chk("f2_done_6401", 64'(fd[6401]), 64'd1);

    // rsp_valid held high, inputs changed mid-frame, back-to-back frames.
    div = 1; ph = 0;
    cyc();
    set_rsp(2'd3, 2'd0, 32'hCAFEF00D, 32'hFFFFFFFF);
    n_op = 2'd1; n_st = 2'd2; n_key = 32'h11111111; n_val = 32'h22222222;
    rif.rsp_valid = 1'b1;
    run_frame(1601, 1'b1, 500, 0, 0);
    decode("f3", 16, 80'hA3_CAFEF00D_FFFFFFFF_6A);
    rdy_hi = 0;
    for (int c = 1; c <= 1601; c++) if (rdy[c] !== 1'b0) rdy_hi++;
    chk("f3_ready_high_cycles", 64'(rdy_hi), 64'd0);
    chk("f3_done_1601", 64'(fd[1601]), 64'd1);
    cyc();
    chk("f3_first_idle_ready", 64'(rif.rsp_ready), 64'd1);
    run_frame(1601, 1'b0, 0, 0, 0);
    decode("f4", 16, 80'hA9_11111111_22222222_A9);
    chk("f4_done_1601", 64'(fd[1601]), 64'd1);

    // Reset during byte 3 with a new response already waiting.
    cyc();
    set_rsp(2'd1, 2'd1, 32'h0BADC0DE, 32'h76543210);
    rif.rsp_valid = 1'b1;
    run_frame(520, 1'b0, 0, 0, 0);
    rdy_hi = 0;
    for (int c = 1; c <= 520; c++) if (fd[c] !== 1'b0) rdy_hi++;
    chk("f5_partial_no_done", 64'(rdy_hi), 64'd0);
    rst = 1'b1;
    set_rsp(2'd0, 2'd2, 32'h00000001, 32'h80000000);
    rif.rsp_valid = 1'b1;
    cyc();
    chk("f5_rst_tx", 64'(dcom_tx), 64'd1);
    chk("f5_rst_ready", 64'(rif.rsp_ready), 64'd1);
    chk("f5_rst_busy", 64'(busy), 64'd0);
    chk("f5_rst_frame_done", 64'(frame_done), 64'd0);
    rst = 1'b0;
    run_frame(1601, 1'b0, 0, 0, 0);
    decode("f6", 16, 80'hA8_00000001_80000000_29);
    chk("f6_done_1601", 64'(fd[1601]), 64'd1);

    // tick_in low for 500 clocks in the middle of bit 12.
    cyc();
    set_rsp(2'd1, 2'd0, 32'h0F0F0F0F, 32'h55AA55AA);
    rif.rsp_valid = 1'b1;
    run_frame(2101, 1'b0, 0, 200, 500);
    held = 0;
    for (int c = 200; c <= 700; c++) if (lvl[c] !== lvl[200]) held++;
    chk("f7_stall_line_changes", 64'(held), 64'd0);
    chk("f7_done_2100", 64'(fd[2100]), 64'd0);
    chk("f7_done_2101", 64'(fd[2101]), 64'd1);

    repeat (4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
